// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: fetch PC, credit-limited imem requests, in-order fetch queue.
// Optional zero-latency response bypass when YSYX_22041412_IFU_BYPASS_EN is defined.
module ysyx_22041412_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst
);

  // state | meaning
  // FETCH | normal fetch, responses pushed into the queue
  // DRAIN | discarding drop_cnt stale responses after a redirect
  typedef enum logic {FETCH, DRAIN} state_t;

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FQ_DEPTH);

  state_t        state;
  logic [63:0]   pc_q, rsp_pc;
  logic [CW-1:0] count, inflight, drop_cnt;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [63:0]   fq_pc   [FQ_DEPTH];
  logic [31:0]   fq_inst [FQ_DEPTH];

  logic          rsp_ok, req_fire, q_valid, bypass, push, pop;
  logic [CW:0]   credit_used;
  logic [CW-1:0] drop_next;
  logic [63:0]   redir_pc_w;
  logic          unused_rpc;

  assign unused_rpc  = ^redirect_pc[1:0];
  assign redir_pc_w  = {redirect_pc[63:2], 2'b00};

  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp_ok      = imem_rsp_valid && (inflight != '0);
  assign credit_used = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid = rst && (state == FETCH) && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_fire    = imem_req_valid && imem_req_ready;
  assign drop_next   = inflight - CW'(rsp_ok);

  assign q_valid = (count != '0);
`ifdef YSYX_22041412_IFU_BYPASS_EN
  assign bypass = !q_valid && (state == FETCH) && !redirect_valid && rsp_ok;
`else
  assign bypass = 1'b0;
`endif
  assign out_valid = q_valid || bypass;
  assign out_pc    = q_valid ? fq_pc[rd_ptr]   : (bypass ? rsp_pc        : 64'd0);
  assign out_inst  = q_valid ? fq_inst[rd_ptr] : (bypass ? imem_rsp_data : 32'd0);

  assign pop  = q_valid && out_ready;
  assign push = rsp_ok && (state == FETCH) && !(bypass && out_ready);

  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      fq_pc[wr_ptr]   <= rsp_pc;
      fq_inst[wr_ptr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      pc_q     <= RESET_PC;
      rsp_pc   <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      // No request can fire this cycle, so what remains in flight is stale.
      pc_q     <= redir_pc_w;
      rsp_pc   <= redir_pc_w;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= drop_next;
      drop_cnt <= drop_next;
      state    <= (drop_next != '0) ? DRAIN : FETCH;
    end else begin
      if (req_fire) pc_q <= pc_q + 64'd4;
      inflight <= inflight + CW'(req_fire) - CW'(rsp_ok);
      if (state == FETCH) begin
        if (rsp_ok) rsp_pc <= rsp_pc + 64'd4;
      end else if (rsp_ok) begin
        drop_cnt <= drop_cnt - CW'(1);
        if (drop_cnt == CW'(1)) state <= FETCH;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
